nn_infer_sequencer: RTL and testbench
=====================================

# nn_infer_sequencer

Sequencer for the fixed-point MNIST inference datapath. On a start pulse it walks the 784-pixel image buffer and the weight ROM through a two-layer fully connected network (ReLU hidden layer, linear output layer) using one internal multiply-accumulate unit. It then writes the per-digit scores to `Probability` and selects the winning digit. It sits between the image buffer/weight ROM and the top level's HEX/LEDR/VGA display logic.

## Interface
- `N_IN`, default 784: input pixels per image.
- `N_HID`, default 32: hidden-layer neurons.
- `N_OUT`, default 10: output neurons (digits).
- `W_AW`, default 15: weight ROM address width.
- `Clk` in 1: single system clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin inference; ignored unless the block is in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse when results are valid.
- `px_addr` out 10: image buffer read address.
- `px_data` in 16: signed Q8.8 pixel, valid 1 cycle after `px_addr`.
- `w_addr` out `W_AW`: weight ROM read address.
- `w_data` in 16: signed Q8.8 weight or bias, valid 1 cycle after `w_addr`.
- `Probability` out 16 x `N_OUT` (unpacked `[N_OUT-1:0]`): signed Q8.8 output scores.
- `digit` out 4: index of the maximum score.

## Operation
- **ROM layout:**
  - Layer-1 neuron n, term i is at address n*(N_IN+1)+i. Term i = N_IN is the bias.
  - Layer-2 base address is B2 = N_HID*(N_IN+1). Neuron m, term j is at B2 + m*(N_HID+1)+j. Term j = N_HID is the bias.
- **States:** IDLE, L1_MAC, L1_WB, L2_MAC, L2_WB, ARGMAX, DONE.
- **IDLE:** when `start`=1, clear neuron counter, term counter and accumulator, then go to L1_MAC.
- **L1_MAC:**
  - Issues term idx = 0..N_IN, one per cycle. `w_addr` gets the idx address; `px_addr` = idx for idx < N_IN.
  - Each cycle, acc += previous cycle's `w_data` * x. x is `px_data` for a pixel term and 0x0100 (1.0) for the bias term.
  - After issuing idx = N_IN, go to L1_WB.
- **L1_WB:**
  - Compute final = acc + last product, then r = sat16(final >>> 8).
  - Store relu(r) to internal hidden register hid[n]; negative r stores 0.
  - Clear acc. Go to L1_MAC for n+1, or to L2_MAC if n = N_HID-1.
- **L2_MAC / L2_WB:** same pattern as layer 1, with these differences:
  - x is hid[j], read through a 1-cycle register so latency matches the ROM.
  - No ReLU.
  - The result is written to `Probability[m]`.
  - After m = N_OUT-1, go to ARGMAX.
- **ARGMAX:**
  - Scans `Probability[0..N_OUT-1]`, one per cycle, as a signed compare.
  - Strict greater-than replaces the running best, so ties resolve to the lowest index.
  - `digit` updates at scan end, then go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Arithmetic:**
  - 16x16 signed product, 32 bits.
  - 40-bit signed accumulator, no intermediate saturation.
  - sat16 clamps to [-32768, 32767].
- **Idle address values:**
  - `px_addr` = 0 outside L1_MAC.
  - `w_addr` = 0 in IDLE, ARGMAX and DONE.
- **Output hold:** `Probability` and `digit` hold their values until overwritten by the next inference.
- **start while busy:** ignored, not queued.
- **Reset:**
  - `Reset_n`=0 at any edge, including mid-inference: state goes to IDLE.
  - `busy`=0, `done`=0, `px_addr`=0, `w_addr`=0, `digit`=0.
  - All `Probability` entries = 0, all hid = 0, accumulator and counters = 0.

## Timing
- **Layer-1 cost:** N_IN+2 cycles per neuron (N_IN+1 MAC + 1 WB).
- **Layer-2 cost:** N_HID+2 cycles per neuron.
- **Latency:** T = N_HID*(N_IN+2) + N_OUT*(N_HID+2) + N_OUT. With defaults, T = 25502.
  - Edge E0 samples `start`=1 in IDLE.
  - `done` is high in the cycle beginning at edge E0+T.
- **busy/done:** `busy` rises at E0 and falls with the `done` cycle's exit edge.
- **Earliest restart:** a new `start` is accepted on the first IDLE cycle after `done`.
- **Probability update:** `Probability[m]` changes at the exit edge of that neuron's L2_WB.

## Test plan
All tests use N_IN=4, N_HID=2, N_OUT=3 (T = 27), with 1-cycle-latency behavioural ROM and image models.
- **Reset values:** hold `Reset_n`=0 for 2 cycles, then release -> `busy`=0, `done`=0, `digit`=0, all `Probability`=0x0000, `px_addr`=0, `w_addr`=0.
- **Uniform network:**
  - Stimulus: all pixels 0x0100, all weights 0x0100, biases 0; pulse `start`.
  - Required: hid = 0x0400 each; `Probability` = {0x0800, 0x0800, 0x0800}; `digit`=0 (tie rule); `done` exactly 27 cycles after the start edge; `busy` high throughout.
- **ReLU and bias:**
  - Stimulus: layer-1 weights 0xFF00 (-1.0), pixels 1.0, layer-2 biases {0x0100, 0x0300, 0xFE00}.
  - Required: hid = 0; `Probability` = {0x0100, 0x0300, 0xFE00}; `digit`=1.
- **Saturation:**
  - Stimulus: pixels 0x7FFF, layer-1 weights 0x7FFF; layer-2 weights 0x0100, biases 0.
  - Required: hid = 0x7FFF; `Probability` = 0x7FFF each (saturated); `digit`=0.
- **Address sequence:** log `w_addr` and `px_addr` against the `Probability`=0x0800 uniform run -> `w_addr` runs 0..4 (neuron 0) then 5..9 (neuron 1), then layer 2 at B2 = 10 and up. `px_addr` runs 0..3 per layer-1 neuron.
- **Robustness:**
  - Pulse `start` at cycle 5 of a run -> ignored, `done` still at cycle 27.
  - Drop `Reset_n` at cycle 15 -> next edge shows IDLE, `busy`=0, `Probability` all 0.
  - A fresh `start` after reset -> correct results, again 27 cycles later.

Source files
------------

// File: rtl/nn_infer_sequencer.sv
// Sequencer for a two-layer fully connected MNIST network (ReLU hidden layer,
// linear output layer) built around one multiply-accumulate unit, plus argmax.
module nn_infer_sequencer #(
    parameter int N_IN  = 784,
    parameter int N_HID = 32,
    parameter int N_OUT = 10,
    parameter int W_AW  = 15
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [9:0]             px_addr,
    input  logic signed [15:0]     px_data,
    output logic [W_AW-1:0]        w_addr,
    input  logic signed [15:0]     w_data,
    output logic signed [15:0]     Probability [N_OUT-1:0],
    output logic [3:0]             digit
);
    localparam int IW = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 2);
    localparam int NW = $clog2(((N_HID > N_OUT) ? N_HID : N_OUT) + 1);
    localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_L1_MAC, S_L1_WB, S_L2_MAC, S_L2_WB, S_ARGMAX, S_DONE
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [9:0]             px_addr_q;
    logic [W_AW-1:0]        w_addr_q;
    logic [3:0]             digit_q;
    logic [3:0]             best_idx_q;
    logic [IW-1:0]          idx_q;
    logic [NW-1:0]          n_q;
    logic signed [39:0]     acc_q;
    logic signed [15:0]     hid_rd_q;
    logic signed [15:0]     best_q;
    logic signed [15:0]     hid_q  [N_HID];
    logic signed [15:0]     prob_q [N_OUT-1:0];

    logic signed [15:0]     x_d;
    logic signed [31:0]     prod_d;
    logic signed [39:0]     final_d;
    logic signed [15:0]     res_d;
    logic signed [15:0]     cand_d;
    logic                   take_d;

    function automatic logic signed [15:0] sat16(input logic signed [39:0] v);
        if (v > 40'sd32767)  return 16'sh7FFF;
        if (v < -40'sd32768) return 16'sh8000;
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] relu(input logic signed [15:0] v);
        return v[15] ? 16'sd0 : v;
    endfunction

    // The product uses the previous cycle's ROM word; the bias term is w_data * 1.0.
    always_comb begin
        x_d     = (state_q == S_L1_MAC) ? px_data : hid_rd_q;
        prod_d  = 32'(w_data) * 32'(x_d);
        final_d = acc_q + (40'(w_data) <<< 8);
        res_d   = sat16(final_d >>> 8);
        cand_d  = prob_q[idx_q[OW-1:0]];
        take_d  = (idx_q == '0) || (cand_d > best_q);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            px_addr_q  <= '0;
            w_addr_q   <= '0;
            digit_q    <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            idx_q      <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            hid_rd_q   <= '0;
            hid_q      <= '{default: '0};
            prob_q     <= '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_L1_MAC;
                        busy_q    <= 1'b1;
                        idx_q     <= '0;
                        n_q       <= '0;
                        acc_q     <= '0;
                        w_addr_q  <= '0;
                        px_addr_q <= '0;
                    end
                end
                S_L1_MAC: begin
                    if (idx_q != '0) acc_q <= acc_q + 40'(prod_d);
                    w_addr_q <= w_addr_q + 1'b1;
                    if (idx_q == IW'(N_IN)) begin
                        state_q   <= S_L1_WB;
                        px_addr_q <= '0;
                    end else begin
                        idx_q     <= idx_q + 1'b1;
                        px_addr_q <= (idx_q + 1'b1 < IW'(N_IN)) ? 10'(idx_q + 1'b1) : '0;
                    end
                end
                S_L1_WB: begin
                    hid_q[n_q[HW-1:0]] <= relu(res_d);
                    acc_q <= '0;
                    idx_q <= '0;
                    if (n_q == NW'(N_HID - 1)) begin
                        state_q <= S_L2_MAC;
                        n_q     <= '0;
                    end else begin
                        state_q <= S_L1_MAC;
                        n_q     <= n_q + 1'b1;
                    end
                end
                // Hidden values go through hid_rd_q so they line up with the ROM latency.
                S_L2_MAC: begin
                    if (idx_q != '0) acc_q <= acc_q + 40'(prod_d);
                    hid_rd_q <= (idx_q < IW'(N_HID)) ? hid_q[idx_q[HW-1:0]] : 16'sd0;
                    w_addr_q <= w_addr_q + 1'b1;
                    if (idx_q == IW'(N_HID)) state_q <= S_L2_WB;
                    else                     idx_q   <= idx_q + 1'b1;
                end
                S_L2_WB: begin
                    prob_q[n_q[OW-1:0]] <= res_d;
                    acc_q <= '0;
                    idx_q <= '0;
                    if (n_q == NW'(N_OUT - 1)) begin
                        state_q  <= S_ARGMAX;
                        w_addr_q <= '0;
                    end else begin
                        state_q <= S_L2_MAC;
                        n_q     <= n_q + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    if (take_d) begin
                        best_q     <= cand_d;
                        best_idx_q <= 4'(idx_q);
                    end
                    if (idx_q == IW'(N_OUT - 1)) begin
                        digit_q <= take_d ? 4'(idx_q) : best_idx_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign px_addr     = px_addr_q;
    assign w_addr      = w_addr_q;
    assign digit       = digit_q;
    assign Probability = prob_q;
endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Bench for nn_infer_sequencer: small network, behavioural ROM/image, reference model.
module tb_nn_infer_sequencer;
    localparam int N_IN  = 4;
    localparam int N_HID = 2;
    localparam int N_OUT = 3;
    localparam int W_AW  = 15;
    localparam int B2    = N_HID * (N_IN + 1);
    localparam int T     = N_HID * (N_IN + 2) + N_OUT * (N_HID + 2) + N_OUT;
    localparam int ROM_N = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic [9:0]           px_addr;
    logic signed [15:0]   px_data;
    logic [W_AW-1:0]      w_addr;
    logic signed [15:0]   w_data;
    logic signed [15:0]   prob [N_OUT-1:0];
    logic [3:0]           digit;

    logic signed [15:0]   rom [ROM_N];
    logic signed [15:0]   img [N_IN];
    longint               exp_hid  [N_HID];
    longint               exp_prob [N_OUT];
    int                   exp_digit;
    int                   ew [64];
    int                   ep [64];
    int                   checks = 0;
    int                   failures = 0;

    nn_infer_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W_AW(W_AW)) dut (
        .Clk(clk), .Reset_n(rst_n), .start(start), .busy(busy), .done(done),
        .px_addr(px_addr), .px_data(px_data), .w_addr(w_addr), .w_data(w_data),
        .Probability(prob), .digit(digit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data  <= (int'(w_addr) < ROM_N) ? rom[w_addr[5:0]] : 16'sd0;
        px_data <= (int'(px_addr) < N_IN) ? img[px_addr[1:0]] : 16'sd0;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic signed [15:0] rsmall();
        return 16'(int'($urandom_range(0, 1024)) - 512);
    endfunction

    // Reference: dot products in plain integer arithmetic, then Q8.8 rescale.
    task automatic compute_ref();
        longint s;
        for (int n = 0; n < N_HID; n++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++)
                s += longint'(rom[n*(N_IN+1)+i]) * longint'(img[i]);
            s += longint'(rom[n*(N_IN+1)+N_IN]) * 256;
            s = clamp16(s >>> 8);
            exp_hid[n] = (s < 0) ? 0 : s;
        end
        for (int m = 0; m < N_OUT; m++) begin
            s = 0;
            for (int j = 0; j < N_HID; j++)
                s += longint'(rom[B2+m*(N_HID+1)+j]) * exp_hid[j];
            s += longint'(rom[B2+m*(N_HID+1)+N_HID]) * 256;
            exp_prob[m] = clamp16(s >>> 8);
        end
        exp_digit = 0;
        for (int m = 1; m < N_OUT; m++)
            if (exp_prob[m] > exp_prob[exp_digit]) exp_digit = m;
    endtask

    // Expected per-cycle addresses, -1 meaning "not constrained".
    task automatic build_addr();
        int c;
        c = 0;
        for (int n = 0; n < N_HID; n++) begin
            for (int i = 0; i <= N_IN; i++) begin
                ew[c] = n*(N_IN+1) + i;
                ep[c] = (i < N_IN) ? i : -1;
                c++;
            end
            ew[c] = -1; ep[c] = 0; c++;
        end
        for (int m = 0; m < N_OUT; m++) begin
            for (int j = 0; j <= N_HID; j++) begin
                ew[c] = B2 + m*(N_HID+1) + j;
                ep[c] = 0;
                c++;
            end
            ew[c] = -1; ep[c] = 0; c++;
        end
        for (int k = 0; k <= N_OUT; k++) begin
            ew[c] = 0; ep[c] = 0; c++;
        end
    endtask

    task automatic fill(input int mode);
        logic signed [15:0] b2v [N_OUT];
        b2v[0] = 16'sh0100; b2v[1] = 16'sh0300;
        b2v[2] = (mode == 3) ? 16'sh0300 : 16'shFE00;
        for (int a = 0; a < ROM_N; a++) rom[a] = 16'sd0;
        for (int i = 0; i < N_IN; i++) begin
            case (mode)
                2:       img[i] = 16'sh7FFF;
                4:       img[i] = 16'($urandom_range(0, 512));
                5:       img[i] = 16'($urandom);
                default: img[i] = 16'sh0100;
            endcase
        end
        for (int n = 0; n < N_HID; n++)
            for (int i = 0; i <= N_IN; i++) begin
                case (mode)
                    0:       rom[n*(N_IN+1)+i] = (i < N_IN) ? 16'sh0100 : 16'sd0;
                    1, 3:    rom[n*(N_IN+1)+i] = (i < N_IN) ? 16'shFF00 : 16'sd0;
                    2:       rom[n*(N_IN+1)+i] = (i < N_IN) ? 16'sh7FFF : 16'sd0;
                    4:       rom[n*(N_IN+1)+i] = rsmall();
                    default: rom[n*(N_IN+1)+i] = 16'($urandom);
                endcase
            end
        for (int m = 0; m < N_OUT; m++)
            for (int j = 0; j <= N_HID; j++) begin
                case (mode)
                    0, 2:    rom[B2+m*(N_HID+1)+j] = (j < N_HID) ? 16'sh0100 : 16'sd0;
                    1, 3:    rom[B2+m*(N_HID+1)+j] = (j < N_HID) ? 16'sh0100 : b2v[m];
                    4:       rom[B2+m*(N_HID+1)+j] = rsmall();
                    default: rom[B2+m*(N_HID+1)+j] = 16'($urandom);
                endcase
            end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_digit"}, longint'(digit), 0);
        check({tag, "_px_addr"}, longint'(px_addr), 0);
        check({tag, "_w_addr"}, longint'(w_addr), 0);
        for (int m = 0; m < N_OUT; m++)
            check($sformatf("%s_prob%0d", tag, m), longint'(prob[m]), 0);
    endtask

    task automatic do_run(input string tag, input int poke_at, input int rst_at);
        int lat;
        int addr_err;
        int busy_err;
        bit aborted;
        lat = -1; addr_err = 0; busy_err = 0; aborted = 1'b0;
        compute_ref();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= T + 8; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            start = (c == poke_at);
            if (c == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                check_idle_zero({tag, "_midrst"});
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (c <= T) begin
                if (ew[c] >= 0 && int'(w_addr) != ew[c]) addr_err++;
                if (ep[c] >= 0 && int'(px_addr) != ep[c]) addr_err++;
                if (!busy) busy_err++;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check({tag, "_latency"}, lat, T);
            check({tag, "_addr_seq_errs"}, addr_err, 0);
            check({tag, "_busy_drops"}, busy_err, 0);
            for (int n = 0; n < N_HID; n++)
                check($sformatf("%s_hid%0d", tag, n), longint'(dut.hid_q[n]), exp_hid[n]);
            for (int m = 0; m < N_OUT; m++)
                check($sformatf("%s_prob%0d", tag, m), longint'(prob[m]), exp_prob[m]);
            check({tag, "_digit"}, longint'(digit), exp_digit);
            @(posedge clk); #1;
            check({tag, "_busy_after"}, longint'(busy), 0);
            check({tag, "_done_after"}, longint'(done), 0);
            check({tag, "_prob0_hold"}, longint'(prob[0]), exp_prob[0]);
        end
    endtask

    initial begin
        int extra;
        fill(0);
        build_addr();
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_zero("post_release");

        fill(0);
        do_run("uniform", -1, -1);
        check("uniform_p0_lit", longint'(prob[0]), 2048);
        check("uniform_p2_lit", longint'(prob[2]), 2048);
        check("uniform_hid1_lit", longint'(dut.hid_q[1]), 1024);

        fill(1);
        do_run("relu", -1, -1);
        check("relu_p2_lit", longint'(prob[2]), -512);
        check("relu_digit_lit", longint'(digit), 1);

        fill(2);
        do_run("sat", -1, -1);
        check("sat_p1_lit", longint'(prob[1]), 32767);

        fill(3);
        do_run("tie", -1, -1);

        fill(0);
        do_run("poke", 5, -1);
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy || done) extra++;
        end
        check("poke_not_queued", extra, 0);

        fill(4);
        do_run("abort", -1, 15);
        fill(0);
        do_run("after_rst", -1, -1);

        for (int r = 0; r < 6; r++) begin
            fill((r % 2 == 0) ? 4 : 5);
            do_run($sformatf("rand%0d", r), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
